// File: rtl/jtkunio_objrom_slot.sv
// Object ROM slot: serves 32-bit fetches via two-beat 16-bit SDRAM bursts.
// Define JTKUNIO_OBJROM_CACHE2_EN for a two-entry cache with 1-bit LRU.
module jtkunio_objrom_slot #(
   parameter int             AW     = 18,
   parameter int             SDW    = 22,
   parameter logic [SDW-1:0] OFFSET = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rom_cs,
   input  logic [AW-1:0]  rom_addr,
   output logic [31:0]    rom_data,
   output logic           rom_ok,
   output logic           sdram_req,
   output logic [SDW-1:0] sdram_addr,
   input  logic           sdram_ack,
   input  logic           sdram_dst,
   input  logic [15:0]    sdram_data,
   output logic           busy
);

   typedef enum logic [1:0] { IDLE, REQ, DATA } state_t;

`ifdef JTKUNIO_OBJROM_CACHE2_EN
   localparam int NE = 2;
   logic lru;
`else
   localparam int NE = 1;
`endif

   state_t        state, state_nxt;
   logic [NE-1:0] valid, match;
   logic [AW-1:0] tag [NE];
   logic [31:0]   data [NE];
   logic [31:0]   hit_data, last_data;
   logic [AW-1:0] req_addr;
   logic [15:0]   beat0;
   logic          cnt, hit, fill, vic;

   always_comb begin
      for (int i = 0; i < NE; i++)
         match[i] = valid[i] && (tag[i] == rom_addr);
   end

   // entry 0 wins when both tags match
   assign hit_data = match[0] ? data[0] : data[NE-1];
   assign hit      = rom_cs & (|match);
   assign rom_ok   = hit;
   assign rom_data = hit ? hit_data : last_data;
   assign busy     = state != IDLE;
   assign fill     = (state == DATA) && sdram_dst && cnt;

`ifdef JTKUNIO_OBJROM_CACHE2_EN
   assign vic = lru;
`else
   assign vic = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (rom_cs && !hit) state_nxt = REQ;
         REQ:     if (sdram_ack) state_nxt = DATA;
         DATA:    if (fill) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         req_addr   <= '0;
         beat0      <= '0;
         cnt        <= 1'b0;
         last_data  <= '0;
      end else begin
         last_data <= rom_data;
         unique case (state)
            IDLE: if (rom_cs && !hit) begin
               req_addr   <= rom_addr;
               sdram_req  <= 1'b1;
               sdram_addr <= OFFSET + SDW'(rom_addr);
            end
            // a beat arriving with the ack is beat 0
            REQ: if (sdram_ack) begin
               sdram_req <= 1'b0;
               cnt       <= sdram_dst;
               if (sdram_dst) beat0 <= sdram_data;
            end
            DATA: if (sdram_dst) begin
               cnt <= ~cnt;
               if (!cnt) beat0 <= sdram_data;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < NE; i++) begin
            tag[i]  <= '0;
            data[i] <= '0;
         end
`ifdef JTKUNIO_OBJROM_CACHE2_EN
         lru <= 1'b0;
`endif
      end else begin
         for (int i = 0; i < NE; i++) begin
            if (fill && i == int'(vic)) begin
               valid[i] <= 1'b1;
               tag[i]   <= req_addr;
               data[i]  <= {sdram_data, beat0};
            end
         end
`ifdef JTKUNIO_OBJROM_CACHE2_EN
         if (fill)     lru <= ~vic;
         else if (hit) lru <= match[0];
`endif
      end
   end

endmodule

// File: tb/tb_jtkunio_objrom_slot.sv
// Bench for jtkunio_objrom_slot: directed bursts, queue-based scoreboard.
`timescale 1ns/1ps
module tb_jtkunio_objrom_slot;

   localparam int AW  = 18;
   localparam int SDW = 22;
   localparam logic [SDW-1:0] OFF = 22'h01_0000;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rom_cs = 1'b0;
   logic [AW-1:0]  rom_addr = '0;
   logic [31:0]    rom_data;
   logic           rom_ok;
   logic           sdram_req;
   logic [SDW-1:0] sdram_addr;
   logic           sdram_ack = 1'b0;
   logic           sdram_dst = 1'b0;
   logic [15:0]    sdram_data = '0;
   logic           busy;

   jtkunio_objrom_slot #(.AW(AW), .SDW(SDW), .OFFSET(OFF)) dut (
      .clk(clk), .rst(rst),
      .rom_cs(rom_cs), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_ok(rom_ok),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr),
      .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
      .sdram_data(sdram_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [SDW-1:0] q_req[$];
   logic [49:0]    q_ok[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // monitor: pops an expectation whenever the DUT presents a response
   logic          prev_req = 1'b0;
   logic          prev_ok = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (sdram_req && !prev_req) begin
            if (q_req.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL req_unexpected: got %0h want none", sdram_addr);
            end else chk("req_addr", 64'(sdram_addr), 64'(q_req.pop_front()));
         end
         if (rom_ok && (!prev_ok || rom_addr != prev_addr)) begin
            if (q_ok.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL ok_unexpected: got %0h/%0h want none", rom_addr, rom_data);
            end else chk("ok_word", 64'({rom_addr, rom_data}), 64'(q_ok.pop_front()));
         end
      end
      prev_req  = sdram_req && !rst;
      prev_ok   = rom_ok;
      prev_addr = rom_addr;
   end

   task automatic wait_req();
      int n = 0;
      while (!sdram_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 64'(sdram_req), 64'(1));
   endtask

   task automatic do_ack();
      wait_req();
      repeat (2) @(posedge clk);
      #1 sdram_ack = 1'b1;
      @(posedge clk);
      #1 sdram_ack = 1'b0;
      @(negedge clk);
      chk("req_drop", 64'(sdram_req), 64'(0));
      chk("busy_data", 64'(busy), 64'(1));
   endtask

   task automatic beat(input logic [15:0] d);
      @(posedge clk);
      #1 sdram_dst = 1'b1; sdram_data = d;
      @(posedge clk);
      #1 sdram_dst = 1'b0;
   endtask

   task automatic miss(input logic [AW-1:0] a, input logic [15:0] d0, d1);
      @(posedge clk);
      #1 rom_cs = 1'b1; rom_addr = a;
      q_req.push_back(OFF + SDW'(a));
      q_ok.push_back({a, d1, d0});
      do_ack();
      beat(d0);
      @(negedge clk);
      chk("ok_early", 64'(rom_ok), 64'(0));
      beat(d1);
      @(negedge clk);
      chk("ok_fill", 64'(rom_ok), 64'(1));
      chk("data_fill", 64'(rom_data), 64'({d1, d0}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req", 64'(sdram_req), 64'(0));
      chk("rst_addr", 64'(sdram_addr), 64'(0));
      chk("rst_data", 64'(rom_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // cold miss
      miss(18'h00100, 16'h1234, 16'h5678);

      // cs drop holds data, re-raise hits immediately
      @(posedge clk);
      #1 rom_cs = 1'b0;
      @(negedge clk);
      chk("cs_low_ok", 64'(rom_ok), 64'(0));
      chk("cs_low_hold", 64'(rom_data), 64'(32'h5678_1234));
      @(posedge clk);
      #1 rom_cs = 1'b1;
      q_ok.push_back({18'h00100, 32'h5678_1234});
      @(negedge clk);
      chk("hit_ok", 64'(rom_ok), 64'(1));
      repeat (3) @(negedge clk);
      chk("hit_noreq", 64'(sdram_req), 64'(0));

      // stray dst while idle and deselected
      @(posedge clk);
      #1 rom_cs = 1'b0; sdram_dst = 1'b1; sdram_data = 16'hdead;
      @(posedge clk);
      #1 sdram_dst = 1'b0;
      @(negedge clk);
      chk("stray_busy", 64'(busy), 64'(0));
      chk("stray_ok", 64'(rom_ok), 64'(0));
      chk("stray_req", 64'(sdram_req), 64'(0));
      @(posedge clk);
      #1 rom_cs = 1'b1;
      q_ok.push_back({18'h00100, 32'h5678_1234});
      @(negedge clk);
      chk("retain_data", 64'(rom_data), 64'(32'h5678_1234));

      // alternation between two addresses
      miss(18'h00300, 16'haaaa, 16'h5555);
      for (int i = 0; i < 4; i++) begin
`ifdef JTKUNIO_OBJROM_CACHE2_EN
         @(posedge clk);
         #1 rom_addr = (i % 2 == 0) ? 18'h00100 : 18'h00300;
         q_ok.push_back({rom_addr,
                         (i % 2 == 0) ? 32'h5678_1234 : 32'h5555_aaaa});
         @(negedge clk);
         chk("alt_ok", 64'(rom_ok), 64'(1));
         chk("alt_noreq", 64'(sdram_req), 64'(0));
`else
         if (i % 2 == 0) miss(18'h00100, 16'h1234, 16'h5678);
         else            miss(18'h00300, 16'haaaa, 16'h5555);
`endif
      end

      // reset clears the cache
      @(posedge clk);
      #1 rst = 1'b1; rom_addr = 18'h00100;
      @(negedge clk);
      chk("rst2_ok", 64'(rom_ok), 64'(0));
      chk("rst2_data", 64'(rom_data), 64'(0));
      @(posedge clk);
      q_req.push_back(OFF + 22'h100);
      #1 rst = 1'b0;

      // address moves mid-burst: fill lands under the old tag
      do_ack();
      rom_addr = 18'h00200;
      q_req.push_back(OFF + 22'h200);
      beat(16'h1111);
      beat(16'h2222);
      @(negedge clk);
      chk("stale_ok", 64'(rom_ok), 64'(0));
      q_ok.push_back({18'h00200, 32'h4444_3333});
      do_ack();
      beat(16'h3333);
      @(negedge clk);
      chk("ok_early2", 64'(rom_ok), 64'(0));
      beat(16'h4444);
      @(negedge clk);
      chk("ok_fill2", 64'(rom_ok), 64'(1));
      chk("data_fill2", 64'(rom_data), 64'(32'h4444_3333));

      // reset between the two beats
      @(posedge clk);
      #1 rom_addr = 18'h00400;
      q_req.push_back(OFF + 22'h400);
      do_ack();
      beat(16'h7777);
      @(posedge clk);
      #2 rst = 1'b1; rom_addr = 18'h00200;
      #1;
      chk("mid_rst_req", 64'(sdram_req), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_ok", 64'(rom_ok), 64'(0));
      rom_cs = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 sdram_dst = 1'b1; sdram_data = 16'hbeef;
      @(posedge clk);
      #1 sdram_dst = 1'b0;
      @(negedge clk);
      chk("late_busy", 64'(busy), 64'(0));
      chk("late_req", 64'(sdram_req), 64'(0));
      miss(18'h00200, 16'h9999, 16'h8888);

      repeat (3) @(negedge clk);
      chk("q_req_left", 64'(q_req.size()), 64'(0));
      chk("q_ok_left", 64'(q_ok.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
